// File: rtl/cic_agc_controller.sv
// Peak-tracking AGC that steps the CIC gain word with hysteresis and pipeline-settle gaps.
// Optional CIC_AGC_FAST_ATTACK_EN: a full-scale sample aborts the window with an immediate step down.
module cic_agc_controller #(
  parameter int unsigned DATA_WIDTH     = 12,
  parameter int unsigned GAIN_WIDTH     = 8,
  parameter int unsigned GAIN_MAX       = 52,
  parameter int unsigned WINDOW_LOG2    = 8,
  parameter int unsigned SETTLE_SAMPLES = 8,
  parameter int unsigned HIGH_THRESH    = 1536,
  parameter int unsigned LOW_THRESH     = 512
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [GAIN_WIDTH-1:0]        manual_gain,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic                         data_clk,
  output logic [GAIN_WIDTH-1:0]        gain,
  output logic                         locked,
  output logic                         window_done,
  output logic [DATA_WIDTH-2:0]        peak
);

  localparam int unsigned SCW = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
  localparam logic [DATA_WIDTH-2:0] FullScale = '1;
  localparam logic [DATA_WIDTH-1:0] MinNeg    = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [GAIN_WIDTH-1:0] GainMax   = GAIN_WIDTH'(GAIN_MAX);

  typedef enum logic [1:0] {StIdle, StSettle, StMeasure, StDecide} state_e;

  state_e                  state_q, state_d;
  logic                    data_clk_q;
  logic [SCW-1:0]          settle_cnt_q, settle_cnt_d;
  logic [WINDOW_LOG2-1:0]  win_cnt_q, win_cnt_d;
  logic [DATA_WIDTH-2:0]   run_peak_q, run_peak_d;
  logic [DATA_WIDTH-2:0]   peak_q, peak_d;
  logic [GAIN_WIDTH-1:0]   gain_q, gain_d;
  logic                    locked_q, locked_d;
  logic                    abort_q, abort_d;

  logic                    smp;
  logic [DATA_WIDTH-1:0]   neg;
  logic [DATA_WIDTH-2:0]   mag;
  logic [GAIN_WIDTH-1:0]   gain_clamp;
  logic                    above_high, below_low;

  assign smp         = data_clk & ~data_clk_q;
  assign gain_clamp  = (manual_gain > GainMax) ? GainMax : manual_gain;
  assign above_high  = (32'(run_peak_q) >= HIGH_THRESH);
  assign below_low   = (32'(run_peak_q) < LOW_THRESH);
  assign gain        = gain_q;
  assign locked      = locked_q;
  assign peak        = peak_q;
  assign window_done = (state_q == StDecide);

  // Most negative input has no positive twin, so it saturates to full scale.
  always_comb begin
    neg = ~data_in + 1'b1;
    if (data_in == MinNeg) begin
      mag = FullScale;
    end else if (data_in[DATA_WIDTH-1]) begin
      mag = neg[DATA_WIDTH-2:0];
    end else begin
      mag = data_in[DATA_WIDTH-2:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    win_cnt_d    = win_cnt_q;
    run_peak_d   = run_peak_q;
    peak_d       = peak_q;
    gain_d       = gain_q;
    locked_d     = locked_q;
    abort_d      = abort_q;

    if (!enable) begin
      state_d  = StIdle;
      gain_d   = gain_clamp;
      locked_d = 1'b0;
      abort_d  = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          gain_d       = gain_clamp;
          locked_d     = 1'b0;
          settle_cnt_d = '0;
          state_d      = StSettle;
        end
        StSettle: begin
          if (smp) begin
            if (settle_cnt_q == SCW'(SETTLE_SAMPLES - 1)) begin
              settle_cnt_d = '0;
              win_cnt_d    = '0;
              run_peak_d   = '0;
              state_d      = StMeasure;
            end else begin
              settle_cnt_d = settle_cnt_q + 1'b1;
            end
          end
        end
        StMeasure: begin
          if (smp) begin
            if (mag > run_peak_q) run_peak_d = mag;
            win_cnt_d = win_cnt_q + 1'b1;
            if (win_cnt_q == {WINDOW_LOG2{1'b1}}) state_d = StDecide;
`ifdef CIC_AGC_FAST_ATTACK_EN
            if (mag == FullScale) begin
              abort_d = 1'b1;
              state_d = StDecide;
            end
`endif
          end
        end
        StDecide: begin
          peak_d       = run_peak_q;
          win_cnt_d    = '0;
          run_peak_d   = '0;
          settle_cnt_d = '0;
          if (above_high && gain_q != '0) begin
            gain_d = gain_q - 1'b1;
          end else if (below_low && gain_q < GainMax) begin
            gain_d = gain_q + 1'b1;
          end
          // Unchanged gain means in-band or pinned at a limit: both count as locked.
          locked_d = (gain_d == gain_q);
          state_d  = (gain_d == gain_q) ? StMeasure : StSettle;
`ifdef CIC_AGC_FAST_ATTACK_EN
          if (abort_q) begin
            abort_d  = 1'b0;
            peak_d   = FullScale;
            locked_d = 1'b0;
            if (gain_q != '0) begin
              gain_d  = gain_q - 1'b1;
              state_d = StSettle;
            end else begin
              gain_d  = gain_q;
              state_d = StMeasure;
            end
          end
`endif
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      data_clk_q   <= 1'b0;
      settle_cnt_q <= '0;
      win_cnt_q    <= '0;
      run_peak_q   <= '0;
      peak_q       <= '0;
      gain_q       <= '0;
      locked_q     <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_clk_q   <= data_clk;
      settle_cnt_q <= settle_cnt_d;
      win_cnt_q    <= win_cnt_d;
      run_peak_q   <= run_peak_d;
      peak_q       <= peak_d;
      gain_q       <= gain_d;
      locked_q     <= locked_d;
      abort_q      <= abort_d;
    end
  end

endmodule

// File: tb/tb_cic_agc_controller.sv
// Randomized bench for cic_agc_controller against a per-sample behavioural model of the AGC loop.
module tb_cic_agc_controller;

  localparam int WIN  = 16;
  localparam int SET  = 8;
  localparam int GMAX = 52;
  localparam int HI   = 1536;
  localparam int LO   = 512;
  localparam int FULL = 2047;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic [7:0]        manual_gain;
  logic signed [11:0] data_in;
  logic              data_clk;
  logic [7:0]        gain;
  logic              locked;
  logic              window_done;
  logic [10:0]       peak;

  int n_cmp = 0;
  int n_err = 0;

  // Model state, advanced once per delivered sample
  int m_gain, m_locked, m_peak, m_phase, m_cnt, m_run;

  cic_agc_controller #(
    .DATA_WIDTH(12), .GAIN_WIDTH(8), .GAIN_MAX(GMAX), .WINDOW_LOG2(4),
    .SETTLE_SAMPLES(SET), .HIGH_THRESH(HI), .LOW_THRESH(LO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .manual_gain(manual_gain),
    .data_in(data_in), .data_clk(data_clk), .gain(gain), .locked(locked),
    .window_done(window_done), .peak(peak)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampg(input int g);
    return (g > GMAX) ? GMAX : g;
  endfunction

  task automatic model_start();
    m_gain   = clampg(int'(manual_gain));
    m_locked = 0;
    m_phase  = 0;
    m_cnt    = 0;
    m_run    = 0;
  endtask

  // Delivers one sample starting at a negedge; returns at a negedge.
  task automatic send_sample(input int v);
    int mag, g_old, l_old, exp_done, ng, h, l;
    mag = (v < 0) ? -v : v;
    if (mag > FULL) mag = FULL;
    exp_done = 0;
    g_old    = m_gain;
    l_old    = m_locked;
    if (m_phase == 0) begin
      m_cnt++;
      if (m_cnt == SET) begin
        m_phase = 1;
        m_cnt   = 0;
        m_run   = 0;
      end
    end else begin
      if (mag > m_run) m_run = mag;
      m_cnt++;
`ifdef CIC_AGC_FAST_ATTACK_EN
      if (mag == FULL) begin
        exp_done = 1;
        m_peak   = FULL;
        m_locked = 0;
        m_cnt    = 0;
        m_run    = 0;
        if (m_gain > 0) begin
          m_gain  = m_gain - 1;
          m_phase = 0;
        end
      end else
`endif
      if (m_cnt == WIN) begin
        exp_done = 1;
        m_peak   = m_run;
        if (m_run >= HI) ng = (m_gain > 0) ? m_gain - 1 : 0;
        else if (m_run < LO) ng = (m_gain < GMAX) ? m_gain + 1 : GMAX;
        else ng = m_gain;
        m_locked = (ng == m_gain) ? 1 : 0;
        m_phase  = (ng == m_gain) ? 1 : 0;
        m_gain   = ng;
        m_cnt    = 0;
        m_run    = 0;
      end
    end

    data_in  = 12'(v);
    data_clk = 1'b1;
    h = $urandom_range(1, 3);
    l = $urandom_range(2, 4);
    @(negedge clk);
    check("window_done_on_sample", window_done, exp_done);
    check("gain_before_decide", gain, g_old);
    check("locked_before_decide", locked, l_old);
    for (int c = 1; c < h + l; c++) begin
      if (c == h) data_clk = 1'b0;
      @(negedge clk);
      if (c == 1) begin
        check("window_done_single_pulse", window_done, 0);
        if (exp_done != 0) begin
          check("gain_after_decide", gain, m_gain);
          check("locked_after_decide", locked, m_locked);
          check("peak_after_decide", peak, m_peak);
        end
      end
    end
  endtask

  task automatic start_loop(input int mg);
    manual_gain = 8'(mg);
    enable      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    model_start();
  endtask

  task automatic go_idle();
    enable = 1'b0;
    @(negedge clk);
    check("idle_gain", gain, clampg(int'(manual_gain)));
    check("idle_locked", locked, 0);
  endtask

  // Drops enable in the same cycle a strobe arrives; the sample must be discarded.
  task automatic drop_with_strobe();
    data_in  = 12'($urandom_range(0, 4095));
    data_clk = 1'b1;
    enable   = 1'b0;
    @(negedge clk);
    check("drop_no_window_done", window_done, 0);
    check("drop_gain_manual", gain, clampg(int'(manual_gain)));
    check("drop_locked", locked, 0);
    data_clk = 1'b0;
    @(negedge clk);
    check("drop_no_window_done_late", window_done, 0);
  endtask

  function automatic int rand_sample(input int regime);
    int a;
    if ($urandom_range(0, 19) == 0) return ($urandom_range(0, 1) != 0) ? -2048 : FULL;
    case (regime)
      0:       a = $urandom_range(0, 500);
      1:       a = $urandom_range(0, 1400);
      2:       a = $urandom_range(0, 2000);
      default: a = $urandom_range(0, 2047);
    endcase
    return ($urandom_range(0, 1) != 0) ? -a : a;
  endfunction

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    manual_gain = 8'd60;
    data_in     = '0;
    data_clk    = 1'b0;
    #12;
    check("reset_gain", gain, 0);
    check("reset_locked", locked, 0);
    check("reset_window_done", window_done, 0);
    check("reset_peak", peak, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("bypass_clamp_gain", gain, 52);
    check("bypass_locked", locked, 0);
    check("bypass_window_done", window_done, 0);

    for (int i = 0; i < 6; i++) begin
      manual_gain = 8'($urandom_range(0, 80));
      @(negedge clk);
      check("bypass_follow", gain, clampg(int'(manual_gain)));
    end

    // Low signal: gain climbs one step per window to the limit and locks there
    start_loop(10);
    for (int i = 0; i < 1080; i++) send_sample(100);
    check("climb_final_gain", gain, 52);
    check("climb_final_locked", locked, 1);
    go_idle();

    // In-band signal: no change, lock, back-to-back windows
    start_loop(20);
    for (int i = 0; i < SET + 2 * WIN; i++) send_sample(($urandom_range(0, 1) != 0) ? 1000 : -1000);
    check("inband_gain", gain, 20);
    check("inband_locked", locked, 1);
    go_idle();

    // One most-negative sample in a quiet window
    start_loop(30);
    for (int i = 0; i < SET + WIN + 4; i++) begin
      send_sample((i == SET + 5) ? -2048 : int'($urandom_range(0, 300)) - 150);
    end
    check("neg_fullscale_gain", gain, 29);

    // Enable dropped while a strobe fires mid-window, then restart
    drop_with_strobe();
    start_loop(40);
    for (int i = 0; i < SET + WIN; i++) send_sample(200);
    check("restart_gain", gain, 41);
    go_idle();

    for (int b = 0; b < 6; b++) begin
      int regime, n;
      regime = $urandom_range(0, 3);
      n      = $urandom_range(40, 90);
      start_loop($urandom_range(0, 70));
      for (int i = 0; i < n; i++) send_sample(rand_sample(regime));
      drop_with_strobe();
    end

    // Asynchronous reset in the middle of settling
    start_loop(25);
    for (int i = 0; i < 4; i++) send_sample(100);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_gain", gain, 0);
    check("async_reset_locked", locked, 0);
    check("async_reset_window_done", window_done, 0);
    check("async_reset_peak", peak, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    model_start();
    for (int i = 0; i < SET + WIN; i++) send_sample(100);
    check("post_reset_gain", gain, 26);
    go_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
